// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
//
// Walks a song table held in an external synchronous ROM and drives the tone
// generator. Each table entry is {half_period, dur_ms}. For every entry the
// sequencer fetches the word, latches the half-period, holds the tone for
// dur_ms milliseconds and then inserts a silent gap of GAP_MS milliseconds.
// A dur_ms of zero marks the end of the song. The millisecond time base is
// derived locally from ticks_per_milli.
//
// Ports
//   clk              clock
//   rst              asynchronous active-high reset
//   ticks_per_milli  clk cycles per millisecond (0 behaves as 1)
//   start            1-cycle pulse, begin playback at entry 0 (ignored when busy)
//   stop             1-cycle pulse, abort playback (wins over start)
//   loop_en          restart from entry 0 at the end of the song
//   rom_addr         table index; ROM data is expected one cycle later
//   rom_data         {half_period, dur_ms} from the ROM
//   half_period      half-period for the tone generator (held after stop)
//   tone_en          tone generator enable
//   busy             high whenever the sequencer is not idle
//   done             1-cycle pulse at the natural end of a song
//   led              {busy, tone_en, note index zero-extended to 6 bits}
// -----------------------------------------------------------------------------
module note_sequencer #(
   parameter  int SONG_LEN = 16,
   parameter  int PER_W    = 16,
   parameter  int DUR_W    = 10,
   parameter  int GAP_MS   = 1,
   localparam int IDX_W    = $clog2(SONG_LEN)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [15:0]            ticks_per_milli,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   loop_en,
   output logic [IDX_W-1:0]       rom_addr,
   input  logic [PER_W+DUR_W-1:0] rom_data,
   output logic [PER_W-1:0]       half_period,
   output logic                   tone_en,
   output logic                   busy,
   output logic                   done,
   output logic [7:0]             led
);

   // Gap counter only needs to reach GAP_MS-1.
   localparam int GAP_W = (GAP_MS > 1) ? $clog2(GAP_MS) : 1;
   localparam bit HAS_GAP = (GAP_MS > 0);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SONG_LEN - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_MS > 0) ? (GAP_MS - 1) : 0);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_PLAY,
      ST_GAP,
      ST_ADV,
      ST_END
   } state_t;

   state_t             state_reg;
   logic [IDX_W-1:0]   idx_reg;
   logic [15:0]        presc_reg;
   logic [DUR_W-1:0]   dur_cnt_reg;
   logic [GAP_W-1:0]   gap_cnt_reg;
   logic [PER_W-1:0]   half_period_reg;
   logic               tone_en_reg;
   logic               busy_reg;
   logic               done_reg;

   logic [15:0]        presc_last;
   logic               timing_active;
   logic               ms_tick;
   logic [PER_W-1:0]   rom_period;
   logic [DUR_W-1:0]   rom_dur;
   logic [5:0]         led_idx;

   // ticks_per_milli of 0 is treated as 1, so the last count is 0 in both cases.
   assign presc_last = (ticks_per_milli == 16'd0) ? 16'd0 : (ticks_per_milli - 16'd1);

   assign timing_active = (state_reg == ST_PLAY) || (state_reg == ST_GAP);

   // A ">=" compare rather than "==" so that lowering ticks_per_milli below
   // the current count mid-note fires the tick at once instead of waiting for
   // the 16-bit counter to wrap around.
   assign ms_tick = timing_active && (presc_reg >= presc_last);

   assign rom_period = rom_data[PER_W+DUR_W-1:DUR_W];
   assign rom_dur    = rom_data[DUR_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         idx_reg         <= '0;
         presc_reg       <= '0;
         dur_cnt_reg     <= '0;
         gap_cnt_reg     <= '0;
         half_period_reg <= '0;
         tone_en_reg     <= 1'b0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
      end else begin
         done_reg <= 1'b0;

         // Millisecond prescaler; wrapping on the tick also clears it on
         // the PLAY->GAP transition.
         if (timing_active) begin
            presc_reg <= ms_tick ? 16'd0 : (presc_reg + 16'd1);
         end

         if (stop) begin
            // Abort from anywhere; half_period and idx are left as they are.
            state_reg   <= ST_IDLE;
            tone_en_reg <= 1'b0;
            busy_reg    <= 1'b0;
            presc_reg   <= '0;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  if (start) begin
                     idx_reg   <= '0;
                     busy_reg  <= 1'b1;
                     state_reg <= ST_FETCH;
                  end
               end

               // rom_addr follows idx_reg, so the ROM word appears in LOAD.
               ST_FETCH: begin
                  state_reg <= ST_LOAD;
               end

               ST_LOAD: begin
                  if (rom_dur == '0) begin
                     state_reg <= ST_END;
                  end else begin
                     half_period_reg <= rom_period;
                     tone_en_reg     <= (rom_period != '0);
                     dur_cnt_reg     <= rom_dur;
                     presc_reg       <= '0;
                     state_reg       <= ST_PLAY;
                  end
               end

               ST_PLAY: begin
                  if (ms_tick) begin
                     dur_cnt_reg <= dur_cnt_reg - DUR_ONE;
                     if (dur_cnt_reg == DUR_ONE) begin
                        tone_en_reg <= 1'b0;
                        if (HAS_GAP) begin
                           gap_cnt_reg <= '0;
                           state_reg   <= ST_GAP;
                        end else begin
                           state_reg <= ST_ADV;
                        end
                     end
                  end
               end

               ST_GAP: begin
                  if (ms_tick) begin
                     if (gap_cnt_reg == GAP_LAST) begin
                        state_reg <= ST_ADV;
                     end else begin
                        gap_cnt_reg <= gap_cnt_reg + GAP_ONE;
                     end
                  end
               end

               ST_ADV: begin
                  if (idx_reg == IDX_LAST) begin
                     state_reg <= ST_END;
                  end else begin
                     idx_reg   <= idx_reg + IDX_ONE;
                     state_reg <= ST_FETCH;
                  end
               end

               // Looping needs idx!=0 so an empty song cannot spin forever.
               ST_END: begin
                  if (loop_en && (idx_reg != '0)) begin
                     idx_reg   <= '0;
                     state_reg <= ST_FETCH;
                  end else begin
                     done_reg    <= 1'b1;
                     tone_en_reg <= 1'b0;
                     busy_reg    <= 1'b0;
                     state_reg   <= ST_IDLE;
                  end
               end

               default: begin
                  tone_en_reg <= 1'b0;
                  busy_reg    <= 1'b0;
                  state_reg   <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // Note index on the LEDs, zero-extended (or truncated) to 6 bits.
   for (genvar gi = 0; gi < 6; gi++) begin : g_led_idx
      if (gi < IDX_W) begin : g_bit
         assign led_idx[gi] = idx_reg[gi];
      end else begin : g_zero
         assign led_idx[gi] = 1'b0;
      end
   end

   assign rom_addr    = idx_reg;
   assign half_period = half_period_reg;
   assign tone_en     = tone_en_reg;
   assign busy        = busy_reg;
   assign done        = done_reg;
   assign led         = {busy_reg, tone_en_reg, led_idx};

endmodule

// File: tb/tb_note_sequencer.sv
// -----------------------------------------------------------------------------
// tb_note_sequencer
//
// Drives note_sequencer with directed and random songs. A reference model
// expands each song into the expected per-cycle outputs from note lengths
// (FETCH, LOAD, dur*tpm tone cycles, GAP_MS*tpm silent cycles, ADV, END),
// and every cycle is compared against it. One line is printed per song.
// -----------------------------------------------------------------------------
module tb_note_sequencer;

   localparam int SONG_LEN = 16;
   localparam int PER_W    = 16;
   localparam int DUR_W    = 10;
   localparam int GAP_MS   = 1;
   localparam int IDX_W    = 4;

   logic                   clk = 1'b0;
   logic                   rst = 1'b0;
   logic [15:0]            tpm = 16'd1;
   logic                   start = 1'b0;
   logic                   stop = 1'b0;
   logic                   loop_en = 1'b0;
   logic [IDX_W-1:0]       rom_addr;
   logic [PER_W+DUR_W-1:0] rom_data = '0;
   logic [PER_W-1:0]       half_period;
   logic                   tone_en;
   logic                   busy;
   logic                   done;
   logic [7:0]             led;

   note_sequencer #(
      .SONG_LEN(SONG_LEN),
      .PER_W   (PER_W),
      .DUR_W   (DUR_W),
      .GAP_MS  (GAP_MS)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ticks_per_milli(tpm),
      .start          (start),
      .stop           (stop),
      .loop_en        (loop_en),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .half_period    (half_period),
      .tone_en        (tone_en),
      .busy           (busy),
      .done           (done),
      .led            (led)
   );

   always #5 clk = ~clk;

   // Synchronous song ROM.
   logic [PER_W+DUR_W-1:0] rom [SONG_LEN];
   always @(posedge clk) rom_data <= rom[rom_addr];

   typedef struct packed {
      logic        busy;
      logic        tone;
      logic [15:0] hp;
      logic [3:0]  addr;
      logic        done;
   } cyc_t;

   cyc_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] model_hp = 16'd0;

   task automatic check_value(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, actual, expected, $time);
      end
   endtask

   task automatic push(input bit b, input bit t, input logic [15:0] h, input int a, input bit d);
      cyc_t c;
      c.busy = b; c.tone = t; c.hp = h; c.addr = a[3:0]; c.done = d;
      exp_q.push_back(c);
   endtask

   // Expected cycle-by-cycle outputs, starting with the cycle after start is sampled.
   task automatic build_expect(input int tpm_i, input bit loop_i, input int limit, output bit ended);
      int          t_eff;
      int          idx;
      int          d;
      logic [15:0] p;
      logic [15:0] hp;
      logic [PER_W+DUR_W-1:0] word;
      t_eff = (tpm_i == 0) ? 1 : tpm_i;
      idx   = 0;
      hp    = model_hp;
      ended = 1'b0;
      exp_q.delete();
      while (exp_q.size() < limit && !ended) begin
         push(1, 0, hp, idx, 0);                   // fetch
         push(1, 0, hp, idx, 0);                   // load
         word = rom[idx];
         p = word[PER_W+DUR_W-1:DUR_W];
         d = int'(word[DUR_W-1:0]);
         if (d != 0) begin
            hp = p;
            repeat (d * t_eff) push(1, p != 0, hp, idx, 0);
            repeat (GAP_MS * t_eff) push(1, 0, hp, idx, 0);
            push(1, 0, hp, idx, 0);                // advance
            if (idx != SONG_LEN - 1) begin
               idx++;
               continue;
            end
         end
         push(1, 0, hp, idx, 0);                   // end of song
         if (loop_i && idx != 0) begin
            idx = 0;
         end else begin
            push(0, 0, hp, idx, 1);
            push(0, 0, hp, idx, 0);
            ended = 1'b1;
         end
      end
      if (!ended) begin
         while (exp_q.size() > limit) void'(exp_q.pop_back());
      end
   endtask

   task automatic compare_cycle(input string tag, input cyc_t e);
      logic [7:0] led_exp;
      led_exp = {e.busy, e.tone, 2'b00, e.addr};
      check_value({tag, ".busy"}, 32'(busy), 32'(e.busy));
      check_value({tag, ".tone_en"}, 32'(tone_en), 32'(e.tone));
      check_value({tag, ".half_period"}, 32'(half_period), 32'(e.hp));
      check_value({tag, ".rom_addr"}, 32'(rom_addr), 32'(e.addr));
      check_value({tag, ".done"}, 32'(done), 32'(e.done));
      check_value({tag, ".led"}, 32'(led), 32'(led_exp));
   endtask

   task automatic check_reset_zero(input string tag);
      cyc_t z;
      z = '0;
      compare_cycle(tag, z);
   endtask

   // Play one song; truncated runs end with stop or an asynchronous reset.
   task automatic run_song(input string name, input int tpm_i, input bit loop_i,
                           input int limit, input bit use_rst);
      bit   ended;
      int   n;
      cyc_t last;
      tpm     = 16'(tpm_i);
      loop_en = loop_i;
      build_expect(tpm_i, loop_i, limit, ended);
      n = exp_q.size();
      @(negedge clk);
      start = 1'b1;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         start = 1'b0;
         compare_cycle(name, exp_q[k]);
         // Stray start pulses while busy must be ignored.
         if (exp_q[k].busy && (k + 1 < n) && ($urandom_range(7) == 0)) start = 1'b1;
      end
      start = 1'b0;
      last  = exp_q[n-1];
      if (!ended) begin
         if (use_rst) begin
            #2 rst = 1'b1;
            #1 check_reset_zero({name, ".rst"});
            #1 rst = 1'b0;
            model_hp = 16'd0;
         end else begin
            stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
            last.busy = 1'b0; last.tone = 1'b0; last.done = 1'b0;
            compare_cycle({name, ".stop"}, last);
            model_hp = last.hp;
         end
      end else begin
         model_hp = last.hp;
      end
      $display("song %s tpm=%0d loop=%0d cycles=%0d %s", name, tpm_i, loop_i, n,
               ended ? "ended" : (use_rst ? "reset" : "stopped"));
   endtask

   task automatic clear_rom();
      for (int i = 0; i < SONG_LEN; i++) rom[i] = '0;
   endtask

   initial begin
      clear_rom();

      // Asynchronous reset, checked before any clock edge.
      #2 rst = 1'b1;
      #1 check_reset_zero("reset");
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      // Single note of 3 ms at 4 cycles/ms.
      clear_rom();
      rom[0] = {16'd100, 10'd3};
      rom[1] = {16'd7, 10'd0};
      run_song("single_note", 4, 0, 1000, 0);

      // Rest, then a short note, then end.
      clear_rom();
      rom[0] = {16'd0, 10'd2};
      rom[1] = {16'd50, 10'd1};
      rom[2] = {16'd9, 10'd0};
      run_song("rest_gap", 2, 0, 1000, 0);

      // Full table, looping, then the same table without looping.
      for (int i = 0; i < SONG_LEN; i++) rom[i] = {16'(i * 11 + 3), 10'd1};
      run_song("full_loop", 1, 1, 110, 0);
      run_song("full_once", 1, 0, 1000, 0);

      // Stop while entry 2 is playing.
      for (int i = 0; i < SONG_LEN; i++) rom[i] = {16'(200 + i), 10'd2};
      run_song("stop_play2", 2, 0, 22, 0);

      // start and stop together while idle: stays idle.
      @(negedge clk);
      start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      check_value("start_stop.busy", 32'(busy), 32'd0);
      check_value("start_stop.done", 32'(done), 32'd0);
      @(negedge clk);
      check_value("start_stop.busy2", 32'(busy), 32'd0);
      $display("song start_stop_idle busy=%0b", busy);

      // tpm=0 plays as 1 cycle per ms.
      rom[0] = {16'd321, 10'd3};
      rom[1] = {16'd0, 10'd0};
      run_song("tpm_zero", 0, 0, 1000, 0);

      // Empty song with loop enabled must still finish.
      rom[0] = {16'd555, 10'd0};
      run_song("empty_loop", 0, 1, 1000, 0);

      // Random songs.
      for (int s = 0; s < 24; s++) begin
         for (int i = 0; i < SONG_LEN; i++) begin
            logic [15:0] p;
            logic [9:0]  d;
            p = ($urandom_range(3) == 0) ? 16'd0 : 16'($urandom_range(65535, 1));
            d = ($urandom_range(5) == 0) ? 10'd0 : 10'($urandom_range(4, 1));
            rom[i] = {p, d};
         end
         run_song($sformatf("rand%0d", s), int'($urandom_range(3)), 1'($urandom_range(1)),
                  int'($urandom_range(250, 15)), ($urandom_range(5) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
